// File: rtl/song_pkg.sv
// Shared encodings, ROM entry layout and the three song tables for song_player.
package song_pkg;

  localparam logic [1:0] ST_START  = 2'd0;
  localparam logic [1:0] ST_MENU   = 2'd1;
  localparam logic [1:0] ST_PLAY   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_ARMED   = 2'd1,
    P_PLAYING = 2'd2,
    P_DONE    = 2'd3
  } player_state_e;

  localparam logic [3:0]  END_MARK    = 4'hF;
  localparam int unsigned ENTRY_W     = 7;
  localparam int unsigned NUM_ENTRIES = 16;

  typedef struct packed {
    logic [3:0] pitch;
    logic [2:0] dur;
  } note_entry_t;

  localparam logic [ENTRY_W-1:0] END_ENTRY = {END_MARK, 3'd0};

  // Song 1: short tune with a rest and a zero-duration entry.
  localparam logic [ENTRY_W-1:0] SONG1_TBL [NUM_ENTRIES] = '{
    {4'd5, 3'd2}, {4'd0, 3'd1}, {4'd7, 3'd3}, {4'd8, 3'd0},
    END_ENTRY, END_ENTRY, END_ENTRY, END_ENTRY,
    END_ENTRY, END_ENTRY, END_ENTRY, END_ENTRY,
    END_ENTRY, END_ENTRY, END_ENTRY, END_ENTRY
  };

  // Song 2: fills all 16 slots, so it ends through the index limit.
  localparam logic [ENTRY_W-1:0] SONG2_TBL [NUM_ENTRIES] = '{
    {4'd1,  3'd2}, {4'd2,  3'd1}, {4'd3,  3'd1}, {4'd4,  3'd2},
    {4'd5,  3'd1}, {4'd6,  3'd1}, {4'd7,  3'd2}, {4'd8,  3'd1},
    {4'd9,  3'd1}, {4'd10, 3'd2}, {4'd11, 3'd1}, {4'd12, 3'd1},
    {4'd13, 3'd2}, {4'd14, 3'd1}, {4'd1,  3'd1}, {4'd2,  3'd0}
  };

  // Song 3: fixed diagnostic pattern.
  localparam logic [ENTRY_W-1:0] SONG3_TBL [NUM_ENTRIES] = '{
    {4'd1, 3'd1}, {4'd2, 3'd2}, {4'd3, 3'd1}, END_ENTRY,
    END_ENTRY, END_ENTRY, END_ENTRY, END_ENTRY,
    END_ENTRY, END_ENTRY, END_ENTRY, END_ENTRY,
    END_ENTRY, END_ENTRY, END_ENTRY, END_ENTRY
  };

  // A zero duration plays for one beat.
  function automatic logic [2:0] eff_dur(input logic [2:0] d);
    return (d == 3'd0) ? 3'd1 : d;
  endfunction

endpackage

// File: rtl/song_player_rom.sv
// Combinational note table lookup; song id 0 reads as end-of-song everywhere.
module song_rom
  import song_pkg::*;
(
  input  logic [1:0]         song_id_i,
  input  logic [3:0]         idx_i,
  output logic [ENTRY_W-1:0] entry_c
);

  always_comb begin
    entry_c = END_ENTRY;
    case (song_id_i)
      2'd1:    entry_c = SONG1_TBL[idx_i];
      2'd2:    entry_c = SONG2_TBL[idx_i];
      2'd3:    entry_c = SONG3_TBL[idx_i];
      default: entry_c = END_ENTRY;
    endcase
  end

endmodule

// File: rtl/song_player.sv
// Playback engine: latches the confirmed song and steps its note table at a
// fixed beat rate while the controller is in PLAY, then pulses finish.
module song_player
  import song_pkg::*;
#(
  parameter int unsigned CLK_PER_BEAT = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] state,
  input  logic [1:0] song_confirm,
  output logic [3:0] note,
  output logic       note_valid,
  output logic [3:0] note_idx,
  output logic       busy,
  output logic       finish
);

  localparam int unsigned   PW         = (CLK_PER_BEAT > 1) ? $clog2(CLK_PER_BEAT) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_BEAT - 1);

  player_state_e fsm_q, fsm_d;
  logic [1:0]    song_id_q, song_id_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    beat_q, beat_d;
  logic [2:0]    dur_q, dur_d;
  logic [3:0]    note_q, note_d;
  logic          valid_q, valid_d;
  logic [3:0]    idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          finish_q, finish_d;

  logic [3:0]         rom_idx;
  logic [ENTRY_W-1:0] rom_entry;
  note_entry_t        ent;
  logic               presc_wrap;
  logic               beat_done;
  logic               last_note;

  // ARMED fetches entry 0; PLAYING prefetches the entry after the current one.
  assign rom_idx = (fsm_q == P_PLAYING) ? 4'(idx_q + 4'd1) : 4'd0;

  song_rom u_rom (
    .song_id_i (song_id_q),
    .idx_i     (rom_idx),
    .entry_c   (rom_entry)
  );

  assign ent        = note_entry_t'(rom_entry);
  assign presc_wrap = (presc_q == PRESC_LAST);
  assign beat_done  = presc_wrap && ((beat_q + 3'd1) == dur_q);
  assign last_note  = (idx_q == 4'd15) || (ent.pitch == END_MARK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q     <= P_IDLE;
      song_id_q <= 2'd0;
      presc_q   <= '0;
      beat_q    <= 3'd0;
      dur_q     <= 3'd0;
      note_q    <= 4'd0;
      valid_q   <= 1'b0;
      idx_q     <= 4'd0;
      busy_q    <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      song_id_q <= song_id_d;
      presc_q   <= presc_d;
      beat_q    <= beat_d;
      dur_q     <= dur_d;
      note_q    <= note_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      finish_q  <= finish_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    song_id_d = song_id_q;
    presc_d   = presc_q;
    beat_d    = beat_q;
    dur_d     = dur_q;
    note_d    = note_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    finish_d  = 1'b0;

    case (fsm_q)
      P_IDLE: begin
        if (song_confirm != 2'd0) begin
          song_id_d = song_confirm;
          fsm_d     = P_ARMED;
        end
      end

      P_ARMED: begin
        if (state == ST_PLAY) begin
          fsm_d   = P_PLAYING;
          idx_d   = 4'd0;
          presc_d = '0;
          beat_d  = 3'd0;
          note_d  = ent.pitch;
          dur_d   = eff_dur(ent.dur);
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          if (song_confirm != 2'd0) song_id_d = song_confirm;
          if (state == ST_START) fsm_d = P_IDLE;
        end
      end

      P_PLAYING: begin
        if (state != ST_PLAY) begin
          // Abort: silence immediately, no finish pulse.
          fsm_d   = P_IDLE;
          note_d  = 4'd0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          presc_d = presc_wrap ? '0 : PW'(presc_q + PW'(1));
          if (presc_wrap) beat_d = 3'(beat_q + 3'd1);
          if (beat_done) begin
            if (last_note) begin
              finish_d = 1'b1;
              fsm_d    = P_DONE;
              note_d   = 4'd0;
              valid_d  = 1'b0;
              busy_d   = 1'b0;
            end else begin
              idx_d  = 4'(idx_q + 4'd1);
              note_d = ent.pitch;
              dur_d  = eff_dur(ent.dur);
              beat_d = 3'd0;
            end
          end
        end
      end

      P_DONE: begin
        if (state != ST_PLAY) fsm_d = P_IDLE;
      end

      default: fsm_d = P_IDLE;
    endcase
  end

  assign note       = note_q;
  assign note_valid = valid_q;
  assign note_idx   = idx_q;
  assign busy       = busy_q;
  assign finish     = finish_q;

endmodule

// File: tb/tb_song_player.sv
// Self-checking bench for song_player with a beat-schedule reference model.
module tb_song_player;

  localparam int CPB = 4;
  localparam int M_IDLE = 0, M_ARMED = 1, M_PLAY = 2, M_DONE = 3;

  logic       clk;
  logic       rst;
  logic [1:0] st;
  logic [1:0] sc;
  logic [3:0] note;
  logic       note_valid;
  logic [3:0] note_idx;
  logic       busy;
  logic       finish;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  song_player #(.CLK_PER_BEAT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .state        (st),
    .song_confirm (sc),
    .note         (note),
    .note_valid   (note_valid),
    .note_idx     (note_idx),
    .busy         (busy),
    .finish       (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Song contents as written in the song descriptions (effective beats).
  function automatic int bpitch(input int s, input int k);
    case (s)
      1: case (k) 0: return 5; 1: return 0; 2: return 7; 3: return 8; default: return 15; endcase
      2: return (k < 14) ? k + 1 : k - 13;
      3: case (k) 0: return 1; 1: return 2; 2: return 3; default: return 15; endcase
      default: return 15;
    endcase
  endfunction

  function automatic int bdur(input int s, input int k);
    case (s)
      1: case (k) 0: return 2; 1: return 1; 2: return 3; 3: return 1; default: return 0; endcase
      2: return (k == 15) ? 1 : ((k % 3 == 0) ? 2 : 1);
      3: case (k) 0: return 1; 1: return 2; 2: return 1; default: return 0; endcase
      default: return 0;
    endcase
  endfunction

  function automatic int song_beats(input int s);
    int tot = 0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0 && bpitch(s, k) == 15) break;
      tot += bdur(s, k);
    end
    return tot;
  endfunction

  // Which entry is sounding t cycles after note 0 appeared.
  function automatic int idx_at(input int s, input int t);
    int acc = 0;
    for (int k = 0; k < 16; k++) begin
      acc += CPB * bdur(s, k);
      if (t < acc) return k;
    end
    return 15;
  endfunction

  int m_mode, m_sid, m_t, m_idx;
  bit m_fin;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode <= M_IDLE; m_sid <= 0; m_t <= 0; m_idx <= 0; m_fin <= 0;
    end else begin
      m_fin <= 0;
      case (m_mode)
        M_IDLE: if (sc != 0) begin m_sid <= int'(sc); m_mode <= M_ARMED; end
        M_ARMED: begin
          if (st == 2) begin
            m_mode <= M_PLAY; m_t <= 0; m_idx <= 0;
          end else begin
            if (sc != 0) m_sid <= int'(sc);
            if (st == 0) m_mode <= M_IDLE;
          end
        end
        M_PLAY: begin
          if (st != 2) begin
            m_mode <= M_IDLE; m_idx <= idx_at(m_sid, m_t);
          end else if (m_t + 1 == CPB * song_beats(m_sid)) begin
            m_fin <= 1; m_mode <= M_DONE; m_idx <= idx_at(m_sid, m_t);
          end else begin
            m_t <= m_t + 1;
          end
        end
        default: if (st != 2) m_mode <= M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      if (m_mode == M_PLAY) begin
        chk("m_note",  int'(note), bpitch(m_sid, idx_at(m_sid, m_t)));
        chk("m_idx",   int'(note_idx), idx_at(m_sid, m_t));
        chk("m_valid", int'(note_valid), 1);
        chk("m_busy",  int'(busy), 1);
        chk("m_fin",   int'(finish), 0);
      end else begin
        chk("m_note",  int'(note), 0);
        chk("m_idx",   int'(note_idx), m_idx);
        chk("m_valid", int'(note_valid), 0);
        chk("m_busy",  int'(busy), 0);
        chk("m_fin",   int'(finish), int'(m_fin));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // From IDLE/DONE: confirm, then PLAY; returns at the cycle note 0 appears.
  task automatic play(input logic [1:0] s);
    st = 2'd1; sc = 2'd0; step(1);
    sc = s; step(1);
    sc = 2'd0; st = 2'd2; step(1);
  endtask

  task automatic wait_finish(output int cyc, output int max_idx);
    cyc = 0; max_idx = 0;
    while (!finish && cyc < 200) begin
      if (int'(note_idx) > max_idx) max_idx = int'(note_idx);
      step(1); cyc++;
    end
    if (cyc >= 200) chk("finish_timeout", cyc, -1);
  endtask

  int fin_cnt, cyc, mx;

  initial begin
    rst = 1'b0; st = 2'd0; sc = 2'd0;
    @(posedge clk); @(negedge clk);
    cmp_en = 1;
    chk("rst_note", int'(note), 0);
    chk("rst_valid", int'(note_valid), 0);
    chk("rst_idx", int'(note_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fin", int'(finish), 0);
    rst = 1'b1; step(2);

    // Happy path, song 3.
    play(2'd3);
    for (int o = 0; o < 18; o++) begin
      chk("hp_note", int'(note), (o < 4) ? 1 : (o < 12) ? 2 : (o < 16) ? 3 : 0);
      chk("hp_idx", int'(note_idx), (o < 4) ? 0 : (o < 12) ? 1 : 2);
      chk("hp_valid", int'(note_valid), (o < 16) ? 1 : 0);
      chk("hp_fin", int'(finish), (o == 16) ? 1 : 0);
      step(1);
    end

    // Holding PLAY in DONE must not replay or re-pulse.
    fin_cnt = 0;
    repeat (10) begin fin_cnt += int'(finish) + int'(busy); step(1); end
    chk("done_hold", fin_cnt, 0);
    st = 2'd3; step(1);
    play(2'd3);
    chk("replay_idx", int'(note_idx), 0);
    chk("replay_note", int'(note), 1);
    step(16);
    chk("replay_fin", int'(finish), 1);
    st = 2'd1; step(2);

    // Re-select in ARMED.
    sc = 2'd1; step(1);
    sc = 2'd3; step(1);
    sc = 2'd0; st = 2'd2; step(1);
    chk("resel_note0", int'(note), 1);
    step(4);
    chk("resel_note1", int'(note), 2);
    step(12);
    chk("resel_fin", int'(finish), 1);
    st = 2'd1; step(2);

    // Abort mid-song.
    play(2'd3);
    step(5);
    st = 2'd1; step(1);
    chk("abort_valid", int'(note_valid), 0);
    chk("abort_busy", int'(busy), 0);
    fin_cnt = 0;
    repeat (20) begin fin_cnt += int'(finish); step(1); end
    chk("abort_nofin", fin_cnt, 0);
    st = 2'd2; fin_cnt = 0;
    repeat (8) begin fin_cnt += int'(busy); step(1); end
    chk("abort_idle", fin_cnt, 0);
    st = 2'd1; step(1);

    // Song 1: rest entry and zero duration.
    play(2'd1);
    chk("s1_note0", int'(note), 5);
    wait_finish(cyc, mx);
    chk("s1_len", cyc, 28);
    st = 2'd1; step(1);

    // Full 16-entry song.
    play(2'd2);
    wait_finish(cyc, mx);
    chk("s2_len", cyc, 84);
    chk("s2_maxidx", mx, 15);
    chk("s2_lastidx", int'(note_idx), 15);
    st = 2'd1; step(2);

    // Asynchronous reset mid-song.
    play(2'd2);
    step(10);
    #2 rst = 1'b0;
    #1;
    chk("arst_note", int'(note), 0);
    chk("arst_valid", int'(note_valid), 0);
    chk("arst_idx", int'(note_idx), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    fin_cnt = 0;
    repeat (10) begin fin_cnt += int'(finish) + int'(busy); step(1); end
    chk("arst_after", fin_cnt, 0);
    st = 2'd0; step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/song_player.md
# song_player

Playback engine at the far end of the menu/state controller's interface. It consumes the controller's `state` and `song_confirm` outputs, latches the confirmed song, and steps through that song's note table at a fixed beat rate while `state` is PLAY. It drives the current note to the tone/LED-matrix stage and returns the `finish` pulse that moves the controller from PLAY to FINISH.

## Interface
- `CLK_PER_BEAT`, 25_000_000: clock cycles per beat; legal range ≥ 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `state`  in  2  controller state: 0 START, 1 MENU, 2 PLAY, 3 FINISH.
- `song_confirm`  in  2  one-cycle non-zero song id (1..3) on confirm; 0 otherwise.
- `note`  out  4  current pitch code; 0 = rest/silent.
- `note_valid`  out  1  high while a note is being played.
- `note_idx`  out  4  index of the current note within the song.
- `busy`  out  1  high in PLAYING.
- `finish`  out  1  one-cycle pulse when the song ends.

## Operation
- FSM states: IDLE, ARMED, PLAYING, DONE.
  - IDLE: when `song_confirm` ≠ 0, latch it into `song_id` and go to ARMED.
  - ARMED: a new non-zero `song_confirm` re-latches `song_id`. When `state` == PLAY, clear `note_idx`, the beat counter and the prescaler, load entry 0, and go to PLAYING. When `state` == START, go to IDLE.
  - PLAYING: the prescaler counts 0..CLK_PER_BEAT-1. At its wrap the beat counter increments. When the beat counter reaches the entry duration:
    - if `note_idx` == 15, or the next entry is the end marker, pulse `finish` and go to DONE;
    - otherwise increment `note_idx`, load the next entry, and clear the beat counter.
  - DONE: `note_valid` is 0. When `state` ≠ PLAY, go to IDLE.
- Abort: if `state` ≠ PLAY while in PLAYING, go to IDLE on the next edge. `note_valid` drops and no `finish` is issued.
- ROM entry is 7 bits: {pitch[3:0], dur[2:0]}.
  - dur is 1..7 beats; dur 0 is treated as 1.
  - pitch 4'hF is the end marker and is never output.
  - Entry 0 is never an end marker.
- `song_confirm` values while PLAYING or DONE are ignored.
- Widths: prescaler is $clog2(CLK_PER_BEAT) bits; beat counter is 3 bits; `note_idx` wraps only through the finish rule, never numerically.

## Timing
- Reset values: FSM IDLE, `song_id` 0, `note` 0, `note_valid` 0, `note_idx` 0, `busy` 0, `finish` 0, all counters 0.
- All outputs are registered.
- `note`, `note_valid` and `busy` assert on the edge after the first cycle that `state` == PLAY is sampled in ARMED.
- Note k+1 appears exactly CLK_PER_BEAT × dur(k) cycles after note k appears.
- `finish` rises CLK_PER_BEAT × Σdur cycles after note 0 appears, and lasts exactly 1 cycle. `note_valid` and `busy` fall on the same edge.
- `song_confirm` arrives one cycle before `state` enters PLAY. It must be latched in IDLE/ARMED with no extra wait.
- Reset mid-song: all outputs return to reset values immediately (asynchronous), and no `finish` is issued.

## Structure
- Package `song_pkg` holds:
  - localparams for the controller state encodings (START/MENU/PLAY/FINISH);
  - the player FSM encoding;
  - the END_MARK pitch (4'hF);
  - the ROM entry width (7);
  - all three song tables.
- Song 3 is fixed as the diagnostic song: {pitch 1, dur 1}, {pitch 2, dur 2}, {pitch 3, dur 1}, END.
- Sub-module `song_rom` is purely combinational: (`song_id`[1:0], `idx`[3:0]) → entry[6:0]. Song id 0 returns END at every index.

## Test plan
- Reset: hold `rst` low mid-play → all outputs 0 immediately; after release, FSM is in IDLE and `finish` stays 0.
- Happy path, CLK_PER_BEAT=4: `song_confirm`=3 for one cycle, then `state`=PLAY →
  - `note`=1, `note_idx`=0 for 4 cycles;
  - `note`=2, `note_idx`=1 for 8 cycles;
  - `note`=3, `note_idx`=2 for 4 cycles;
  - then a single `finish` pulse 16 cycles after note 0 appears, with `note_valid` 0 from that edge.
- Re-select in ARMED: `song_confirm`=1, then `song_confirm`=3, then PLAY → song 3 sequence plays.
- Abort: `state` forced to MENU at cycle 6 of song 3 → `note_valid` 0 on the next edge, no `finish`, FSM returns to IDLE.
- DONE exit: hold `state`=PLAY for 10 cycles after `finish` → exactly one pulse and no replay. `state`=FINISH → IDLE; a new confirm plus PLAY replays from `note_idx` 0.
- Full-length song: a 16-entry table with no END marker → `finish` asserts after entry 15 completes, and `note_idx` never exceeds 15.
